// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master side issues operands and consumes results; the adder is the slave.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one
// full_adder cell with a registered carry, one bit per clock.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] msb_bit;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_s, fa_co;

   full_adder u_fa (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      msb_bit  = '0;
      msb_bit[WIDTH-1] = fa_s;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = (res_sh_q >> 1) | msb_bit;
            carry_d  = fa_co;
            // Counter holds on the last bit so it never wraps.
            if (cnt_q == LAST) begin
               sum_d   = res_sh_d;
               cout_d  = fa_co;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule
